// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register for an inter-stage boundary.
// It carries a control bundle and a data bundle with a valid bit.
// It supports ready back-pressure and a flush that inserts a bubble.
// With SKID=1 a one-entry skid buffer lets in_ready come from a flop,
// so a long stall chain never forms a combinational ready path.
// With SKID=0 it is a single register with a combinational in_ready.
// The control register is cleared whenever the stage empties.
// This keeps downstream write enables inert in bubbles without output gating.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 75,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic              ready_q, ready_n;
  logic              up_xfer, dn_xfer;

  // With SKID=0 the TWO state is never entered, so the same FSM serves both variants.
  // Only the source of in_ready differs between them.
  assign in_ready  = (SKID != 0) ? ready_q : ((state == EMPTY) || out_ready);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state;
  assign up_xfer   = in_valid && in_ready;
  assign dn_xfer   = out_valid && out_ready;

  // Next-state and register-load decisions; flush overrides everything except reset
  always_comb begin
    state_n     = state;
    main_ctrl_n = main_ctrl;
    main_data_n = main_data;
    skid_ctrl_n = skid_ctrl;
    skid_data_n = skid_data;
    unique case (state)
      EMPTY: begin
        if (up_xfer) begin
          state_n     = ONE;
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end else if (up_xfer && (SKID != 0)) begin
          state_n     = TWO;
          skid_ctrl_n = in_ctrl;
          skid_data_n = in_data;
        end else if (dn_xfer) begin
          state_n     = EMPTY;
          main_ctrl_n = '0;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_n     = ONE;
          main_ctrl_n = skid_ctrl;
          main_data_n = skid_data;
          skid_ctrl_n = '0;
        end
      end
      default: begin
        state_n     = EMPTY;
        main_ctrl_n = '0;
        skid_ctrl_n = '0;
      end
    endcase
    if (flush) begin
      state_n     = EMPTY;
      main_ctrl_n = '0;
      main_data_n = main_data;
      skid_ctrl_n = '0;
      skid_data_n = skid_data;
    end
    ready_n = (state_n != TWO);
  end

  // State, payload and registered-ready flops with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      main_ctrl <= main_ctrl_n;
      main_data <= main_data_n;
      skid_ctrl <= skid_ctrl_n;
      skid_data <= skid_data_n;
      ready_q   <= ready_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench driving a SKID=1 and a SKID=0 instance with shared stimulus.
// Each instance is checked against its own queue-based reference model.
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 75;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  logic [CW+DW-1:0] sb1[$];
  logic [CW+DW-1:0] sb0[$];

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut_flat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkInstance(input string name, input logic rdy, input logic ov,
                               input logic [1:0] occ, input logic [CW-1:0] oc,
                               input logic [DW-1:0] od, input logic exp_rdy,
                               input int size, input logic [CW+DW-1:0] head);
    checkOutput({name, ".in_ready"}, 128'(rdy), 128'(exp_rdy));
    checkOutput({name, ".out_valid"}, 128'(ov), 128'(size != 0));
    checkOutput({name, ".occupancy"}, 128'(occ), 128'(size));
    if (size == 0) begin
      checkOutput({name, ".bubble_ctrl"}, 128'(oc), 128'(0));
    end else begin
      checkOutput({name, ".out_ctrl"}, 128'(oc), 128'(head[CW+DW-1:DW]));
      checkOutput({name, ".out_data"}, 128'(od), 128'(head[DW-1:0]));
    end
  endtask

  // One cycle: drive inputs, check both DUTs against their models, advance models and clock
  task automatic applyStimulus(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl);
    logic exp_rdy1, exp_rdy0;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy1 = (sb1.size() < 2);
    exp_rdy0 = (sb0.size() == 0) || ordy;
    checkInstance("skid", rdy1, ov1, occ1, oc1, od1, exp_rdy1, sb1.size(),
                  (sb1.size() != 0) ? sb1[0] : '0);
    checkInstance("flat", rdy0, ov0, occ0, oc0, od0, exp_rdy0, sb0.size(),
                  (sb0.size() != 0) ? sb0[0] : '0);
    if ((sb1.size() != 0) && ordy) void'(sb1.pop_front());
    if ((sb0.size() != 0) && ordy) void'(sb0.pop_front());
    if (fl) begin
      sb1.delete();
      sb0.delete();
    end else begin
      if (iv && exp_rdy1) sb1.push_back({c, d});
      if (iv && exp_rdy0) sb0.push_back({c, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst.skid.out_valid", 128'(ov1), 128'(0));
    checkOutput("rst.skid.out_ctrl", 128'(oc1), 128'(0));
    checkOutput("rst.skid.occupancy", 128'(occ1), 128'(0));
    checkOutput("rst.skid.in_ready", 128'(rdy1), 128'(1));
    checkOutput("rst.flat.out_valid", 128'(ov0), 128'(0));
    checkOutput("rst.flat.out_ctrl", 128'(oc0), 128'(0));
    checkOutput("rst.flat.occupancy", 128'(occ0), 128'(0));
    checkOutput("rst.flat.in_ready", 128'(rdy0), 128'(1));
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    checkOutput("rst.skid.out_data", 128'(od1), 128'(0));
    reset = 1'b0;
    #1;

    $display("[TB] streaming 0x01..0x08");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 4'(i), DW'(i), 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

    $display("[TB] stall and skid with 0xA1..0xA3");
    applyStimulus(1'b1, 4'h1, DW'(8'hA1), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, DW'(8'hA2), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, DW'(8'hA3), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, DW'(8'hA3), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, DW'(8'hA3), 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h3, DW'(8'hA3), 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

    $display("[TB] flush with a simultaneous input");
    applyStimulus(1'b1, 4'h6, {11'h7FF, 64'hDEAD_BEEF_0BAD_F00D}, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, {11'h123, 64'h0123_4567_89AB_CDEF}, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, DW'(8'hEE), 1'b0, 1'b1);
    applyStimulus(1'b0, 4'hF, DW'(8'hEE), 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b0);

    $display("[TB] flush during a downstream transfer");
    applyStimulus(1'b1, 4'h5, DW'(8'h55), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA, DW'(8'h66), 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

    $display("[TB] pass-through ready and replacement");
    applyStimulus(1'b1, 4'h7, DW'(8'h71), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, DW'(8'h72), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, DW'(8'h72), 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hC, DW'(8'h73), 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

    $display("[TB] bubble control pattern");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(((i % 2) == 0), 4'b1011, DW'(32'hB000 + i), 1'b1, 1'b0);
    end
    repeat (2) applyStimulus(1'b0, 4'b1011, '0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), {11'($urandom), 32'($urandom), 32'($urandom)},
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 8 && (sb1.size() != 0 || sb0.size() != 0); i++) begin
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
    end
    checkOutput("drain.skid", 128'(sb1.size()), 128'(0));
    checkOutput("drain.flat", 128'(sb0.size()), 128'(0));

    $display("[TB] asynchronous reset with two entries held");
    applyStimulus(1'b1, 4'hD, DW'(8'hC1), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, DW'(8'hC2), 1'b0, 1'b0);
    checkOutput("pre_rst.skid.occupancy", 128'(occ1), 128'(2));
    #3;
    reset = 1'b1;
    #1;
    checkResetState();
    sb1.delete();
    sb0.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h3, DW'(8'h99), 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline register for inter-stage boundaries (EX/MEM and peers).
- Carries a control bundle and a data bundle with a valid bit, stall back-pressure via ready, and a flush that inserts a bubble.
- Optional 1-entry skid buffer registers the upstream ready path so long stall chains do not form combinational ready paths.

Parameters:
- CTRL_W, 4, width of control bundle (RegWrite/MemtoReg/MemWrite/MemRead style bits); forced to 0 in bubbles.
- DATA_W, 75, width of data bundle (register indices, funct3, ALU result, store data, flags); not cleared in bubbles.
- SKID, 1, 1 = skid buffer present and in_ready registered; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discard all held and incoming entries this cycle.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  downstream entry present.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  held control bundle; all-zero whenever out_valid=0.
- out_data  output  DATA_W  held data bundle.
- occupancy  output  2  entries held: 0, 1, or 2 (2 only when SKID=1).

Behaviour:
- Reset is asynchronous: out_valid=0, out_ctrl=0, out_data=0, skid register=0, occupancy=0. in_ready=1 immediately (SKID=1: registered 1; SKID=0: derived from out_valid=0).
- Transfers: upstream transfer when in_valid & in_ready; downstream transfer when out_valid & out_ready.
- Latency: 1 cycle from an accepted input to out_valid when the stage is empty.
- Ordering: entries leave in arrival order; no duplication and no loss except on flush.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - Accept loads the main register. Downstream transfer without an accept clears out_valid.
- SKID=1 state machine, states EMPTY(0), ONE(1), TWO(2); occupancy = state:
  - EMPTY: on accept -> ONE, main <= input.
  - ONE, accept only: main full and out_ready=0 -> TWO, skid <= input. Downstream transfer only -> EMPTY. Both at once -> ONE, main <= input.
  - TWO: in_ready=0. On out_ready -> ONE, main <= skid.
  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Flush, highest priority after reset:
  - On the next edge, out_valid=0, out_ctrl=0, occupancy=0, state EMPTY.
  - An input accepted in the flush cycle is dropped.
  - A downstream transfer in the flush cycle still counts; the sink sees the current outputs.
  - out_data keeps its stale value.
- Bubble rule: out_ctrl must be 0 whenever out_valid=0, so downstream write enables are inert. Implement by clearing the control register, not by output gating.
- Boundaries:
  - out_ready=1 with out_valid=0 has no effect.
  - in_valid=0 with in_ready=1 holds state.
  - A stall (out_ready=0) holds out_* stable, bit-exact.
  - Reset asserted mid-transfer clears everything; no entry survives.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges with occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0 before the next edge; in_ready=1.
- Streaming, SKID=1: in_valid=1 for 8 cycles with data 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on consecutive cycles, 1-cycle latency, in_ready never drops.
- Stall/skid: send 0xA1, 0xA2, 0xA3 back-to-back with out_ready=0 from cycle 1 -> occupancy goes 1, 2; in_ready=0 after 0xA2; 0xA3 held upstream. Release out_ready -> outputs 0xA1, 0xA2, 0xA3 in order, none lost.
- Flush with simultaneous input: occupancy=2, in_valid=1 with ctrl=4'hF, flush=1 -> next cycle out_valid=0, out_ctrl=4'h0, occupancy=0, and the flushed input never appears.
- SKID=0 pass-through ready: out_valid=1, out_ready=0 -> in_ready=0 the same cycle. Raise out_ready=1 -> in_ready=1 the same cycle; a new entry replaces the old on the edge.
- Bubble control check: alternate in_valid 1/0 with ctrl=4'b1011 -> out_ctrl=4'b1011 on valid cycles and 4'b0000 on every non-valid cycle.
